multiport_register_file: RTL and testbench

- Parametrised successor to the single-write, dual-read integer register file, for the wider-issue pipeline.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Includes a per-register busy scoreboard (pending-producer bits) for hazard detection in decode.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/multiport_register_file_pkg.sv | 31 +++
 rtl/multiport_register_file_if.sv | 34 +++
 rtl/multiport_register_file_scoreboard.sv | 43 ++++
 rtl/multiport_register_file.sv | 91 +++++++++
 tb/tb_multiport_register_file.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/multiport_register_file_pkg.sv
// Shared types and helpers for the multiport register file.
// Also used by the MULTIPORT_REGFILE_BYPASS_EN read-bypass path.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  // Port-select helpers work on a fixed-width hit vector so one function serves any NWR.
  localparam int MAX_PORTS = 32;
  localparam int PIDX_W    = 5;

  typedef struct packed {
    logic              found;
    logic [PIDX_W-1:0] idx;
  } port_sel_t;

  // The highest-index set bit wins. The same rule resolves write conflicts and picks the bypass source.
  function automatic port_sel_t hi_port(input logic [MAX_PORTS-1:0] hit);
    port_sel_t s;
    s = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (hit[i]) begin
        s.found = 1'b1;
        s.idx   = PIDX_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Decode/writeback bus of the multiport register file.
// The master modport is the pipeline side. The slave modport is the register file.
interface multiport_register_file_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                sb_flush;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/multiport_register_file_scoreboard.sv
// Pending-producer busy bits. Priority order: flush, then writeback clears, then issue set.
// Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              sb_set_en_i,
  input  logic [AW-1:0]     sb_set_addr_i,
  input  logic              sb_flush_i,
  output logic [NREGS-1:0]  busy_vec_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (sb_flush_i) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p]) busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
      // Set comes after clear so that a new producer supersedes the completing one.
      if (sb_set_en_i) busy_d[sb_set_addr_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// NRD combinational read ports and NWR write ports. The highest-index write port wins a conflict.
// Optional same-cycle read bypass: define MULTIPORT_REGFILE_BYPASS_EN.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiport_register_file_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  port_sel_t        wsel   [NREGS];
  logic [NREGS-1:0] busy;

  // Per-register write arbitration.
  assign wsel[REG_ZERO] = '0;
  for (genvar r = 1; r < NREGS; r++) begin : g_wsel
    logic [MAX_PORTS-1:0] hit;
    always_comb begin
      hit = '0;
      for (int p = 0; p < NWR; p++)
        hit[p] = bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == AW'(r));
    end
    assign wsel[r] = hi_port(hit);
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      if (wsel[r].found) regs_d[r] = bus.wr_data[wsel[r].idx*XLEN +: XLEN];
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .sb_set_en_i  (bus.sb_set_en),
    .sb_set_addr_i(bus.sb_set_addr),
    .sb_flush_i   (bus.sb_flush),
    .busy_vec_o   (busy)
  );

  assign bus.busy_vec = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbusy;
    assign ra = bus.rd_addr[k*AW +: AW];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] fhit;
    port_sel_t            fsel;
    logic                 set_here;
    always_comb begin
      fhit = '0;
      for (int p = 0; p < NWR; p++)
        fhit[p] = bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == ra) && (ra != AW'(REG_ZERO));
    end
    assign fsel     = hi_port(fhit);
    assign set_here = bus.sb_set_en && (bus.sb_set_addr == ra);
    assign rdat     = fsel.found ? bus.wr_data[fsel.idx*XLEN +: XLEN] : regs_q[ra];
    // A forwarded result is no longer pending unless a new producer claims the register this cycle.
    assign rbusy    = busy[ra] && !(fsel.found && !set_here);
`else
    assign rdat  = regs_q[ra];
    assign rbusy = busy[ra];
`endif
    // Gating with rst_n keeps the read outputs at 0 while reset is held, even with bypass enabled.
    assign bus.rd_data[k*XLEN +: XLEN] = rst_n ? rdat : '0;
    assign bus.rd_busy[k]              = rst_n & rbusy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (XLEN=64, NREGS=32, two read ports, two write ports).
// Expectations follow MULTIPORT_REGFILE_BYPASS_EN when that macro is defined.
module tb_multiport_register_file;
  import regfile_pkg::*;

  localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiport_register_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  multiport_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic        se;
    logic [4:0]  sa;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [63:0] e_r0, e_r1;
    logic        e_b0, e_b1;
    logic [31:0] e_bv;
  } vec_t;

  typedef struct {
    logic [63:0] r0, r1;
    logic        b0, b1;
    logic [31:0] bv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vec [11];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [63:0] wd0,
                              logic [4:0] wa1, logic [63:0] wd1, logic se, logic [4:0] sa,
                              logic fl, logic [4:0] ra0, logic [4:0] ra1,
                              logic [63:0] er0, logic [63:0] er1, logic eb0, logic eb1,
                              logic [31:0] ebv);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.se = se; v.sa = sa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.e_r0 = er0; v.e_r1 = er1; v.e_b0 = eb0; v.e_b1 = eb1; v.e_bv = ebv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic idle();
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.sb_set_en = 1'b0; bus.sb_set_addr = '0; bus.sb_flush = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    bus.wr_en = v.we;
    bus.wr_addr = {v.wa1, v.wa0};
    bus.wr_data = {v.wd1, v.wd0};
    bus.sb_set_en = v.se;
    bus.sb_set_addr = v.sa;
    bus.sb_flush = v.fl;
    bus.rd_addr = {v.ra1, v.ra0};
    e.r0 = v.e_r0; e.r1 = v.e_r1; e.b0 = v.e_b0; e.b1 = v.e_b1; e.bv = v.e_bv;
    q.push_back(e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, "_rd0"},   bus.rd_data[63:0],   e.r0);
    chk({tag, "_rd1"},   bus.rd_data[127:64], e.r1);
    chk({tag, "_busy0"}, 64'(bus.rd_busy[0]), 64'(e.b0));
    chk({tag, "_busy1"}, 64'(bus.rd_busy[1]), 64'(e.b1));
    chk({tag, "_bvec"},  64'(bus.busy_vec),   64'(e.bv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Rows are applied after one negedge. The edge that follows commits them.
    vec[0]  = mk(2'b11,  5, 64'h1234,  6, 64'hABCD, 0,  0, 0,  5,  6,
                 BYP ? 64'h1234 : 64'h0, BYP ? 64'hABCD : 64'h0, 0, 0, 32'h0);
    vec[1]  = mk(2'b01,  0, 64'hFFFF,  0, 64'h0,    0,  0, 0,  5,  6,
                 64'h1234, 64'hABCD, 0, 0, 32'h0);
    vec[2]  = mk(2'b11,  7, 64'h11,    7, 64'h22,   1,  3, 0,  0,  5,
                 64'h0, 64'h1234, 0, 0, 32'h0);
    vec[3]  = mk(2'b01,  3, 64'h33,    0, 64'h0,    1,  3, 0,  7,  3,
                 64'h22, BYP ? 64'h33 : 64'h0, 0, 1, 32'h8);
    vec[4]  = mk(2'b10,  0, 64'h0,     3, 64'h44,   0,  0, 0,  3,  7,
                 BYP ? 64'h44 : 64'h33, 64'h22, !BYP, 0, 32'h8);
    vec[5]  = mk(2'b00,  0, 64'h0,     0, 64'h0,    1,  4, 1,  3,  3,
                 64'h44, 64'h44, 0, 0, 32'h0);
    vec[6]  = mk(2'b00,  0, 64'h0,     0, 64'h0,    1,  0, 0,  4,  0,
                 64'h0, 64'h0, 0, 0, 32'h0);
    vec[7]  = mk(2'b10,  0, 64'h0,     9, 64'h55,   1, 10, 0,  9, 10,
                 BYP ? 64'h55 : 64'h0, 64'h0, 0, 0, 32'h0);
    vec[8]  = mk(2'b11, 10, 64'h77,   11, 64'h88,   1, 11, 0,  9, 10,
                 64'h55, BYP ? 64'h77 : 64'h0, 0, !BYP, 32'h400);
    vec[9]  = mk(2'b00,  0, 64'h0,     0, 64'h0,    0,  0, 0, 10, 11,
                 64'h77, 64'h88, 0, 1, 32'h800);
    vec[10] = mk(2'b00,  0, 64'h0,     0, 64'h0,    0,  0, 0, 11,  5,
                 64'h88, 64'h1234, 1, 0, 32'h800);

    idle();
    bus.rd_addr = {5'd2, 5'd1};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_rd0",  bus.rd_data[63:0],   64'h0);
    chk("rst_hold_rd1",  bus.rd_data[127:64], 64'h0);
    chk("rst_hold_bvec", 64'(bus.busy_vec),   64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      bus.rd_addr = {5'(NREGS - 1 - r), 5'(r)};
      #1;
      chk($sformatf("rst_rd0_x%0d", r), bus.rd_data[63:0],   64'h0);
      chk($sformatf("rst_rd1_x%0d", NREGS - 1 - r), bus.rd_data[127:64], 64'h0);
    end
    chk("rst_bvec", 64'(bus.busy_vec), 64'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      sample($sformatf("row%0d", i));
    end

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    idle();
    bus.rd_addr = {5'd5, 5'd11};
    #1;
    chk("pre_arst_rd0",   bus.rd_data[63:0],   64'h88);
    chk("pre_arst_rd1",   bus.rd_data[127:64], 64'h1234);
    chk("pre_arst_busy0", 64'(bus.rd_busy[0]), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rd0",   bus.rd_data[63:0],   64'h0);
    chk("arst_rd1",   bus.rd_data[127:64], 64'h0);
    chk("arst_busy0", 64'(bus.rd_busy[0]), 64'h0);
    chk("arst_bvec",  64'(bus.busy_vec),   64'h0);

    // The first edge after release performs a normal update.
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_en = 2'b01;
    bus.wr_addr = {5'd0, 5'd12};
    bus.wr_data = {64'h0, 64'h5A};
    bus.sb_set_en = 1'b1;
    bus.sb_set_addr = 5'd12;
    @(negedge clk);
    idle();
    bus.rd_addr = {5'd5, 5'd12};
    #1;
    chk("post_rst_rd0",   bus.rd_data[63:0],   64'h5A);
    chk("post_rst_rd1",   bus.rd_data[127:64], 64'h0);
    chk("post_rst_busy0", 64'(bus.rd_busy[0]), 64'h1);
    chk("post_rst_bvec",  64'(bus.busy_vec),   64'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
